// File: rtl/emulador_de_teclado.sv
// 4x4 membrane keypad emulator: accepts "press key K for N cycles" commands and
// answers the active-low row scan on the column lines, with press/release contact bounce.
module emulador_de_teclado #(
    parameter int unsigned BOUNCE_CYCLES = 20,
    parameter int unsigned BOUNCE_HALF   = 3,
    parameter int unsigned HOLD_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        lin_matriz,
    output logic [3:0]        col_matriz,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_tecla,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int unsigned PW = (HOLD_W > BW) ? HOLD_W : BW;
    localparam int unsigned TW = (BOUNCE_HALF > 1) ? $clog2(BOUNCE_HALF) : 1;

    localparam logic [PW-1:0] BOUNCE_LOAD = PW'(BOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TOG_LAST    = TW'(BOUNCE_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HELD,
        S_REL_BOUNCE,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic               contact, contact_n;
    logic [PW-1:0]      phase, phase_n;
    logic [TW-1:0]      tog, tog_n;
    logic [1:0]         row_q, row_n;
    logic [1:0]         col_q, col_n;
    logic [HOLD_W-1:0]  hold_q, hold_n;

    // Key code to {row, col} of the physical keypad layout
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        logic [3:0] pos;
        case (code)
            4'h1: pos = {2'd0, 2'd0};
            4'h2: pos = {2'd0, 2'd1};
            4'h3: pos = {2'd0, 2'd2};
            4'hA: pos = {2'd0, 2'd3};
            4'h4: pos = {2'd1, 2'd0};
            4'h5: pos = {2'd1, 2'd1};
            4'h6: pos = {2'd1, 2'd2};
            4'hB: pos = {2'd1, 2'd3};
            4'h7: pos = {2'd2, 2'd0};
            4'h8: pos = {2'd2, 2'd1};
            4'h9: pos = {2'd2, 2'd2};
            4'hC: pos = {2'd2, 2'd3};
            4'hF: pos = {2'd3, 2'd0};
            4'h0: pos = {2'd3, 2'd1};
            4'hE: pos = {2'd3, 2'd2};
            default: pos = {2'd3, 2'd3};
        endcase
        return pos;
    endfunction

    // Hold of zero behaves as one cycle; counter holds remaining cycles minus one
    function automatic logic [PW-1:0] hold_load(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : PW'(h - HOLD_W'(1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            contact   <= 1'b0;
            phase     <= '0;
            tog       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            hold_q    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            contact   <= contact_n;
            phase     <= phase_n;
            tog       <= tog_n;
            row_q     <= row_n;
            col_q     <= col_n;
            hold_q    <= hold_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n   = state;
        contact_n = contact;
        phase_n   = phase;
        tog_n     = tog;
        row_n     = row_q;
        col_n     = col_q;
        hold_n    = hold_q;
        case (state)
            S_IDLE: begin
                contact_n = 1'b0;
                if (cmd_valid) begin
                    {row_n, col_n} = key_pos(cmd_tecla);
                    hold_n         = cmd_hold;
                    contact_n      = 1'b1;
                    tog_n          = '0;
                    if (BOUNCE_CYCLES == 0) begin
                        state_n = S_HELD;
                        phase_n = hold_load(cmd_hold);
                    end else begin
                        state_n = S_PRESS_BOUNCE;
                        phase_n = BOUNCE_LOAD;
                    end
                end
            end
            S_PRESS_BOUNCE, S_REL_BOUNCE: begin
                if (phase == '0) begin
                    tog_n = '0;
                    if (state == S_PRESS_BOUNCE) begin
                        state_n   = S_HELD;
                        contact_n = 1'b1;
                        phase_n   = hold_load(hold_q);
                    end else begin
                        state_n   = S_DONE;
                        contact_n = 1'b0;
                    end
                end else begin
                    phase_n = phase - PW'(1);
                    // Contact chatters: flip every BOUNCE_HALF cycles
                    if (tog == TOG_LAST) begin
                        tog_n     = '0;
                        contact_n = ~contact;
                    end else begin
                        tog_n = tog + TW'(1);
                    end
                end
            end
            S_HELD: begin
                if (phase == '0) begin
                    contact_n = 1'b0;
                    tog_n     = '0;
                    if (BOUNCE_CYCLES == 0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_REL_BOUNCE;
                        phase_n = BOUNCE_LOAD;
                    end
                end else begin
                    phase_n = phase - PW'(1);
                end
            end
            S_DONE: begin
                contact_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                contact_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    // Column sense follows the live row drive with no register in the path
    always_comb begin
        col_matriz = 4'b1111;
        if (contact && !lin_matriz[row_q]) begin
            col_matriz[col_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_emulador_de_teclado.sv
// Directed bench for emulador_de_teclado: one instance without bounce, one with 20/3 bounce.
module tb_emulador_de_teclado;

    logic        clk;
    logic        rst;
    logic [3:0]  lin_matriz;
    logic [3:0]  cmd_tecla;
    logic [15:0] cmd_hold;
    logic        valid0, valid20;
    logic [3:0]  col0, col20;
    logic        ready0, ready20, busy0, busy20, done0, done20;

    int checks = 0;
    int errors = 0;

    emulador_de_teclado #(.BOUNCE_CYCLES(0), .BOUNCE_HALF(3), .HOLD_W(16)) dut0 (
        .clk(clk), .rst(rst), .lin_matriz(lin_matriz), .col_matriz(col0),
        .cmd_valid(valid0), .cmd_ready(ready0), .cmd_tecla(cmd_tecla),
        .cmd_hold(cmd_hold), .busy(busy0), .done(done0)
    );

    emulador_de_teclado #(.BOUNCE_CYCLES(20), .BOUNCE_HALF(3), .HOLD_W(16)) dut20 (
        .clk(clk), .rst(rst), .lin_matriz(lin_matriz), .col_matriz(col20),
        .cmd_valid(valid20), .cmd_ready(ready20), .cmd_tecla(cmd_tecla),
        .cmd_hold(cmd_hold), .busy(busy20), .done(done20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] tecla;
        logic [3:0] lin;
        logic [3:0] exp_col;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command; returns at the first sampling point after the accept edge
    task automatic send(input bit use20, input logic [3:0] t, input logic [15:0] h);
        @(negedge clk);
        cmd_tecla = t;
        cmd_hold  = h;
        if (use20) begin
            valid20 = 1'b1;
            chk("ready_before_accept20", 32'(ready20), 32'd1);
        end else begin
            valid0 = 1'b1;
            chk("ready_before_accept0", 32'(ready0), 32'd1);
        end
        @(negedge clk);
        valid0  = 1'b0;
        valid20 = 1'b0;
    endtask

    function automatic logic [3:0] decode(input logic [3:0] lin, input logic [3:0] col);
        logic [3:0] m [16];
        int r, c;
        m = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (!lin[i]) r = i;
            if (!col[i]) c = i;
        end
        return m[r*4 + c];
    endfunction

    initial begin
        logic [3:0] rot [4];
        logic       closed;

        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        tbl[0]  = '{4'h1, 4'b1110, 4'b1110};
        tbl[1]  = '{4'h2, 4'b1110, 4'b1101};
        tbl[2]  = '{4'h3, 4'b1110, 4'b1011};
        tbl[3]  = '{4'hA, 4'b1110, 4'b0111};
        tbl[4]  = '{4'h4, 4'b1101, 4'b1110};
        tbl[5]  = '{4'h5, 4'b1101, 4'b1101};
        tbl[6]  = '{4'h6, 4'b1101, 4'b1011};
        tbl[7]  = '{4'hB, 4'b1101, 4'b0111};
        tbl[8]  = '{4'h7, 4'b1011, 4'b1110};
        tbl[9]  = '{4'h8, 4'b1011, 4'b1101};
        tbl[10] = '{4'h9, 4'b1011, 4'b1011};
        tbl[11] = '{4'hC, 4'b1011, 4'b0111};
        tbl[12] = '{4'hF, 4'b0111, 4'b1110};
        tbl[13] = '{4'h0, 4'b0111, 4'b1101};
        tbl[14] = '{4'hE, 4'b0111, 4'b1011};
        tbl[15] = '{4'hD, 4'b0111, 4'b0111};
        tbl[16] = '{4'h5, 4'b1110, 4'b1111};
        tbl[17] = '{4'hD, 4'b1011, 4'b1111};
        tbl[18] = '{4'h9, 4'b0011, 4'b1011};
        tbl[19] = '{4'h1, 4'b1111, 4'b1111};

        rst        = 1'b1;
        lin_matriz = 4'b1110;
        cmd_tecla  = 4'h0;
        cmd_hold   = 16'd0;
        valid0     = 1'b0;
        valid20    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_col0", 32'(col0), 32'hF);
        chk("rst_col20", 32'(col20), 32'hF);
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_ready20", 32'(ready20), 32'd1);
        chk("rst_busy20", 32'(busy20), 32'd0);
        rst = 1'b0;

        // Key map table, no bounce, hold 2
        for (int i = 0; i < 20; i++) begin
            lin_matriz = tbl[i].lin;
            send(1'b0, tbl[i].tecla, 16'd2);
            chk($sformatf("map_col_c1_k%0h_l%b", tbl[i].tecla, tbl[i].lin), 32'(col0), 32'(tbl[i].exp_col));
            @(negedge clk);
            chk($sformatf("map_col_c2_k%0h", tbl[i].tecla), 32'(col0), 32'(tbl[i].exp_col));
            @(negedge clk);
            chk($sformatf("map_done_k%0h", tbl[i].tecla), 32'(done0), 32'd1);
            chk($sformatf("map_col_done_k%0h", tbl[i].tecla), 32'(col0), 32'hF);
            @(negedge clk);
        end

        // Key 5 hold 10, own row driven then another row driven
        for (int pass = 0; pass < 2; pass++) begin
            lin_matriz = (pass == 0) ? 4'b1101 : 4'b1110;
            send(1'b0, 4'h5, 16'd10);
            for (int k = 1; k <= 12; k++) begin
                chk($sformatf("k5_col_p%0d_c%0d", pass, k), 32'(col0),
                    (pass == 0 && k <= 10) ? 32'hD : 32'hF);
                chk($sformatf("k5_done_p%0d_c%0d", pass, k), 32'(done0), (k == 11) ? 32'd1 : 32'd0);
                chk($sformatf("k5_busy_p%0d_c%0d", pass, k), 32'(busy0), (k <= 11) ? 32'd1 : 32'd0);
                chk($sformatf("k5_ready_p%0d_c%0d", pass, k), 32'(ready0), (k <= 11) ? 32'd0 : 32'd1);
                @(negedge clk);
            end
        end

        // Key D with a rotating scanner and a small decoder model
        send(1'b0, 4'hD, 16'd16);
        for (int k = 1; k <= 16; k++) begin
            lin_matriz = rot[k % 4];
            #1;
            chk($sformatf("scan_col_c%0d", k), 32'(col0), (rot[k % 4] == 4'b0111) ? 32'h7 : 32'hF);
            if (col0 != 4'hF) begin
                chk("scan_decode", 32'(decode(lin_matriz, col0)), 32'hD);
            end
            @(negedge clk);
        end
        chk("scan_done", 32'(done0), 32'd1);
        @(negedge clk);

        // Bounce pattern, key 1 hold 5, done 46 cycles after accept
        lin_matriz = 4'b1110;
        send(1'b1, 4'h1, 16'd5);
        for (int k = 1; k <= 47; k++) begin
            if (k <= 20)      closed = (((k - 1) / 3) % 2) == 0;
            else if (k <= 25) closed = 1'b1;
            else if (k <= 45) closed = (((k - 26) / 3) % 2) == 1;
            else              closed = 1'b0;
            chk($sformatf("bounce_col_c%0d", k), 32'(col20), closed ? 32'hE : 32'hF);
            chk($sformatf("bounce_done_c%0d", k), 32'(done20), (k == 46) ? 32'd1 : 32'd0);
            chk($sformatf("bounce_ready_c%0d", k), 32'(ready20), (k == 47) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // cmd_valid held through busy: second command waits, hold 0 gives one cycle
        lin_matriz = 4'b1011;
        @(negedge clk);
        cmd_tecla = 4'h7;
        cmd_hold  = 16'd3;
        valid0    = 1'b1;
        @(negedge clk);
        cmd_tecla = 4'h9;
        cmd_hold  = 16'd0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("q_col7_c%0d", k), 32'(col0), 32'hE);
            chk($sformatf("q_ready_c%0d", k), 32'(ready0), 32'd0);
            @(negedge clk);
        end
        chk("q_done7", 32'(done0), 32'd1);
        chk("q_col_done7", 32'(col0), 32'hF);
        @(negedge clk);
        chk("q_ready_idle", 32'(ready0), 32'd1);
        chk("q_busy_idle", 32'(busy0), 32'd0);
        chk("q_col_idle", 32'(col0), 32'hF);
        @(negedge clk);
        valid0 = 1'b0;
        chk("q_col9", 32'(col0), 32'hB);
        chk("q_busy9", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("q_done9", 32'(done0), 32'd1);
        chk("q_col_done9", 32'(col0), 32'hF);
        @(negedge clk);
        chk("q_ready_end", 32'(ready0), 32'd1);

        // Reset in the middle of HELD
        lin_matriz = 4'b1101;
        send(1'b0, 4'h5, 16'd10);
        @(negedge clk);
        @(negedge clk);
        chk("mid_col_before", 32'(col0), 32'hD);
        #2 rst = 1'b1;
        #1;
        chk("mid_col_rst", 32'(col0), 32'hF);
        chk("mid_busy_rst", 32'(busy0), 32'd0);
        chk("mid_ready_rst", 32'(ready0), 32'd1);
        chk("mid_done_rst", 32'(done0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("mid_nodone_c%0d", k), 32'(done0), 32'd0);
            chk($sformatf("mid_col_c%0d", k), 32'(col0), 32'hF);
            @(negedge clk);
        end
        send(1'b0, 4'h5, 16'd2);
        chk("post_col_c1", 32'(col0), 32'hD);
        @(negedge clk);
        chk("post_col_c2", 32'(col0), 32'hD);
        @(negedge clk);
        chk("post_done", 32'(done0), 32'd1);
        @(negedge clk);
        chk("post_ready", 32'(ready0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
